// File: rtl/sid_pkg.sv
// Shared definitions for the SID bus master: register map, command packing
// width and the issue FSM encoding.
package sid_pkg;

  localparam int FIFO_AW_DEF = 4;
  localparam int DLY_W_DEF   = 16;

  localparam logic [4:0] V1_FREQ_LO = 5'h00, V1_FREQ_HI = 5'h01, V1_PW_LO = 5'h02,
                         V1_PW_HI   = 5'h03, V1_CTRL    = 5'h04, V1_AD    = 5'h05,
                         V1_SR      = 5'h06;
  localparam logic [4:0] V2_FREQ_LO = 5'h07, V2_FREQ_HI = 5'h08, V2_PW_LO = 5'h09,
                         V2_PW_HI   = 5'h0A, V2_CTRL    = 5'h0B, V2_AD    = 5'h0C,
                         V2_SR      = 5'h0D;
  localparam logic [4:0] V3_FREQ_LO = 5'h0E, V3_FREQ_HI = 5'h0F, V3_PW_LO = 5'h10,
                         V3_PW_HI   = 5'h11, V3_CTRL    = 5'h12, V3_AD    = 5'h13,
                         V3_SR      = 5'h14;
  localparam logic [4:0] FC_LO = 5'h15, FC_HI = 5'h16, RES_FILT = 5'h17, MODE_VOL = 5'h18;
  localparam logic [4:0] POTX = 5'h19, POTY = 5'h1A, OSC3 = 5'h1B, ENV3 = 5'h1C;

  // Queued command layout is {rd, addr[4:0], data[7:0], delay[dly_w-1:0]}.
  function automatic int cmd_width(input int dly_w);
    return 1 + 5 + 8 + dly_w;
  endfunction

  localparam int CMD_W_DEF = cmd_width(DLY_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

endpackage

// File: rtl/sid_bus_master_if.sv
// Host command / read response / SID register port bundle.
interface sid_bus_master_if
  import sid_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_rd;
  logic [4:0]       cmd_addr;
  logic [7:0]       cmd_data;
  logic [DLY_W-1:0] cmd_delay;
  logic             rsp_valid;
  logic [7:0]       rsp_data;
  logic             sid_we;
  logic [4:0]       sid_addr;
  logic [7:0]       sid_wdata;
  logic [7:0]       sid_rdata;

  modport master (
    input  cmd_valid, cmd_rd, cmd_addr, cmd_data, cmd_delay, sid_rdata,
    output cmd_ready, rsp_valid, rsp_data, sid_we, sid_addr, sid_wdata
  );

  modport slave (
    output cmd_valid, cmd_rd, cmd_addr, cmd_data, cmd_delay, sid_rdata,
    input  cmd_ready, rsp_valid, rsp_data, sid_we, sid_addr, sid_wdata
  );
endinterface

// File: rtl/sid_cmd_fifo.sv
// Single-clock command FIFO with show-ahead head; pointers carry one extra
// wrap bit so full/empty are distinguished without a counter.
module sid_cmd_fifo #(
  parameter int AW = 4,
  parameter int W  = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/sid_bus_master.sv
// SID register bus initiator: queues host commands and issues each one to the
// SID port after its delay in ce_1m ticks, returning read data on a strobe.
module sid_bus_master
  import sid_pkg::*;
#(
  parameter int FIFO_AW = FIFO_AW_DEF,
  parameter int DLY_W   = DLY_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce_1m,
  input  logic                 flush,
  sid_bus_master_if.master     bus,
  output logic                 busy,
  output logic [FIFO_AW:0]     level
);
  localparam int CW = cmd_width(DLY_W);

  logic [CW-1:0]    fifo_din;
  logic [CW-1:0]    fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;
  logic             head_rd;
  logic [4:0]       head_addr;
  logic [7:0]       head_data;
  logic [DLY_W-1:0] head_delay;

  state_e           state_q;
  logic [DLY_W-1:0] cnt_q;
  logic             cur_rd_q;
  logic [4:0]       cur_addr_q;
  logic [7:0]       cur_data_q;
  logic             sid_we_q;
  logic [4:0]       sid_addr_q;
  logic [7:0]       sid_wdata_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_data_q;

  assign bus.cmd_ready = !fifo_full && !reset;
  assign fifo_push     = bus.cmd_valid && bus.cmd_ready && !flush;
  assign fifo_din      = {bus.cmd_rd, bus.cmd_addr, bus.cmd_data, bus.cmd_delay};
  assign fifo_pop      = (state_q == ST_IDLE) && !fifo_empty && !flush;
  assign {head_rd, head_addr, head_data, head_delay} = fifo_dout;

  sid_cmd_fifo #(.AW(FIFO_AW), .W(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_rd_q    <= 1'b0;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
      sid_we_q    <= 1'b0;
      sid_addr_q  <= '0;
      sid_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      sid_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      // A read in progress completes even when a flush arrives in its slot.
      if (state_q == ST_ISSUE && cur_rd_q) begin
        rsp_data_q  <= bus.sid_rdata;
        rsp_valid_q <= 1'b1;
      end
      if (flush) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!fifo_empty) begin
              cur_rd_q   <= head_rd;
              cur_addr_q <= head_addr;
              cur_data_q <= head_data;
              cnt_q      <= head_delay;
              state_q    <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (ce_1m) begin
              if (cnt_q == '0) begin
                state_q    <= ST_ISSUE;
                sid_we_q   <= !cur_rd_q;
                sid_addr_q <= cur_addr_q;
                if (!cur_rd_q) sid_wdata_q <= cur_data_q;
              end else begin
                cnt_q <= cnt_q - DLY_W'(1);
              end
            end
          end
          ST_ISSUE: state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sid_we    = sid_we_q;
  assign bus.sid_addr  = sid_addr_q;
  assign bus.sid_wdata = sid_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = !fifo_empty || (state_q != ST_IDLE);
endmodule

// File: tb/tb_sid_bus_master.sv
// Randomized bench for sid_bus_master: a scoreboard predicts, per command, the
// ce_1m tick after which it issues and the data it must carry.
module tb_sid_bus_master;
  import sid_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_gen = 1'b0;
  logic       ce_man = 1'b0;
  logic       ce_1m;
  logic       flush = 1'b0;
  logic       busy;
  logic [4:0] level;
  bit         ce_auto = 1'b1;

  logic [7:0] sid_regs [32];

  sid_bus_master_if #(.DLY_W(16)) bus ();

  assign ce_1m = ce_gen | ce_man;
  assign bus.sid_rdata = sid_regs[bus.sid_addr];

  sid_bus_master #(.FIFO_AW(4), .DLY_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .ce_1m (ce_1m),
    .flush (flush),
    .bus   (bus),
    .busy  (busy),
    .level (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [4:0]  a;
    logic [7:0]  d;
    int unsigned ce;
  } exp_t;

  exp_t        q[$];
  int unsigned issue_log[$];
  int unsigned ce_cnt = 0;
  int unsigned last_issue = 0;
  int          n_total = 0;
  int          n_bad = 0;
  bit          we_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ce_1m: one-clk pulse every 4..7 clks, so no command can miss a tick.
  initial begin
    forever begin
      int gap;
      gap = int'($urandom_range(7, 4));
      repeat (gap - 1) @(negedge clk);
      if (ce_auto) ce_gen = 1'b1;
      @(negedge clk);
      ce_gen = 1'b0;
    end
  end

  task automatic check_issue(input bit rd);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_access", 32'(rd), 32'hFFFF_FFFF);
    end else begin
      e = q.pop_front();
      chk("kind", 32'(rd), 32'(e.rd));
      chk("addr", 32'(bus.sid_addr), 32'(e.a));
      if (rd) chk("rdata", 32'(bus.rsp_data), 32'(sid_regs[e.a]));
      else    chk("wdata", 32'(bus.sid_wdata), 32'(e.d));
      chk("issue_tick", ce_cnt, e.ce);
      issue_log.push_back(ce_cnt);
      $display("access %s addr=0x%02h data=0x%02h tick=%0d",
               rd ? "rd" : "wr", bus.sid_addr, rd ? bus.rsp_data : bus.sid_wdata, ce_cnt);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ce_1m) ce_cnt++;
      if (reset) begin
        q.delete();
        last_issue = ce_cnt;
        we_prev = 1'b0;
      end else begin
        if (bus.sid_we) begin
          chk("we_single", 32'(we_prev), 32'd0);
          check_issue(1'b0);
        end
        if (bus.rsp_valid) check_issue(1'b1);
        we_prev = bus.sid_we;
        if (flush) begin
          q.delete();
          last_issue = ce_cnt;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the command is accepted.
  task automatic push(input bit rd, input logic [4:0] a, input logic [7:0] d,
                      input logic [15:0] dly);
    int   waitc;
    exp_t e;
    int unsigned start;
    waitc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_rd    = rd;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    bus.cmd_delay = dly;
    #1;
    while (!bus.cmd_ready && waitc < 5000) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!bus.cmd_ready) begin
      chk("push_timeout", 32'(bus.cmd_ready), 32'd1);
    end else begin
      start = ce_cnt + 32'(ce_1m);
      if (last_issue > start) start = last_issue;
      e.rd = rd; e.a = a; e.d = d; e.ce = start + 32'(dly) + 1;
      last_issue = e.ce;
      q.push_back(e);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic sync_ce();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!ce_1m && n < 100);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 40000), 32'd1);
  endtask

  initial begin
    int unsigned c0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rd    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.cmd_delay = '0;
    for (int i = 0; i < 32; i++) sid_regs[i] = 8'($urandom);
    sid_regs[POTX] = 8'hA5;

    // reset state
    repeat (4) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_sid_we", 32'(bus.sid_we), 32'd0);
    chk("rst_sid_addr", 32'(bus.sid_addr), 32'd0);
    chk("rst_sid_wdata", 32'(bus.sid_wdata), 32'd0);
    chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_data}), 32'd0);
    chk("rst_busy_level", 32'({busy, level}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    // 1: single write, zero delay
    sync_ce();
    c0 = ce_cnt;
    issue_log.delete();
    push(1'b0, MODE_VOL, 8'h0F, 16'd0);
    wait_drain("t1");
    chk("t1_count", 32'(issue_log.size()), 32'd1);
    if (issue_log.size() == 1) chk("t1_tick", issue_log[0] - c0, 32'd1);

    // 2: three writes with delays 0, 2, 5
    sync_ce();
    c0 = ce_cnt;
    issue_log.delete();
    push(1'b0, V1_FREQ_LO, 8'h11, 16'd0);
    push(1'b0, V1_FREQ_HI, 8'h22, 16'd2);
    push(1'b0, V1_CTRL,    8'h33, 16'd5);
    wait_drain("t2");
    chk("t2_count", 32'(issue_log.size()), 32'd3);
    if (issue_log.size() == 3) begin
      chk("t2_tick0", issue_log[0] - c0, 32'd1);
      chk("t2_tick1", issue_log[1] - c0, 32'd4);
      chk("t2_tick2", issue_log[2] - c0, 32'd10);
    end

    // 3: read pot_x
    sync_ce();
    push(1'b1, POTX, 8'h00, 16'd0);
    wait_drain("t3");
    chk("t3_rsp_data", 32'(bus.rsp_data), 32'hA5);

    // random mix of reads/writes in short bursts
    for (int it = 0; it < 25; it++) begin
      int n;
      sync_ce();
      n = int'($urandom_range(3, 1));
      for (int k = 0; k < n; k++)
        push(1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 8'($urandom),
             16'($urandom_range(3, 0)));
    end
    wait_drain("rand");

    // 4: fill the FIFO and keep it topped up over 40 commands
    sync_ce();
    for (int i = 0; i < 40; i++) begin
      push(1'b0, 5'($urandom_range(31, 0)), 8'($urandom), 16'd100);
      #1;
      if (i == 16) begin
        chk("t4_level_full", 32'(level), 32'd16);
        chk("t4_ready_full", 32'(bus.cmd_ready), 32'd0);
      end else if (i > 16) begin
        chk("t4_level_hold", 32'(level), 32'd16);
      end
    end
    wait_drain("t4");

    // 5: flush in WAIT with 5 queued; a push in the flush cycle is dropped
    sync_ce();
    for (int i = 0; i < 6; i++) push(1'b0, 5'(i), 8'(8'h40 + i), 16'd50);
    repeat (6) @(negedge clk);
    #1;
    chk("t5_level_before", 32'(level), 32'd5);
    @(negedge clk);
    flush = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = V2_CTRL;
    @(negedge clk);
    flush = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    chk("t5_level_after", 32'(level), 32'd0);
    chk("t5_busy_after", 32'(busy), 32'd0);
    repeat (300) @(negedge clk);
    sync_ce();
    issue_log.delete();
    push(1'b0, V1_CTRL, 8'h41, 16'd1);
    wait_drain("t5");
    chk("t5_new_count", 32'(issue_log.size()), 32'd1);

    // 6: reset during ISSUE of a read
    ce_auto = 1'b0;
    repeat (10) @(negedge clk);
    push(1'b1, ENV3, 8'h00, 16'd0);
    repeat (4) @(negedge clk);
    ce_man = 1'b1;
    @(negedge clk);
    ce_man = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_issue_addr", 32'(bus.sid_addr), 32'(ENV3));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("t6_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    chk("t6_outs", 32'({bus.sid_we, bus.sid_addr, bus.sid_wdata, bus.rsp_data}), 32'd0);
    chk("t6_busy_level", 32'({busy, level}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_ready_release", 32'(bus.cmd_ready), 32'd1);
    ce_auto = 1'b1;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
